// File: rtl/ad_sample_capture_pkg.sv
// Shared types and constants for the ADC sample-capture front end.
package ad_sample_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAdRst,
    StWaitTick,
    StConvst,
    StSettle,
    StWaitBusy,
    StRdLo,
    StRdHi
  } state_e;

  localparam int unsigned DefaultDw = 16;
  localparam int unsigned OvfW      = 16;
  localparam int unsigned TimerW    = 16;

  function automatic logic [OvfW-1:0] sat_inc(input logic [OvfW-1:0] v);
    return (v == {OvfW{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ad_sample_capture_if.sv
// Parallel ADC bus: the controller drives the strobes, the converter drives data/status.
interface ad_sample_capture_if #(
  parameter int unsigned Dw = ad_sample_capture_pkg::DefaultDw
) ();
  logic [Dw-1:0] ad_data;
  logic          ad_busy;
  logic          first_data;
  logic          ad_reset;
  logic          ad_convst_n;
  logic          ad_cs_n;
  logic          ad_rd_n;

  modport master (
    input  ad_data, ad_busy, first_data,
    output ad_reset, ad_convst_n, ad_cs_n, ad_rd_n
  );

  modport slave (
    output ad_data, ad_busy, first_data,
    input  ad_reset, ad_convst_n, ad_cs_n, ad_rd_n
  );
endinterface

// File: rtl/ad_sample_capture_rd_seq.sv
// Read-phase timer: times the RD low/high strobe phases and tracks the channel being read.
module ad_sample_capture_rd_seq
  import ad_sample_capture_pkg::*;
#(
  parameter int unsigned Channels = 8,
  parameter int unsigned RdLow    = 2,
  parameter int unsigned RdHigh   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_lo,
  input  logic in_hi,
  output logic lo_done,
  output logic hi_done,
  output logic first_chan,
  output logic last_chan
);

  localparam int unsigned ChW = (Channels > 1) ? $clog2(Channels) : 1;

  logic [TimerW-1:0] timer_q, timer_d;
  logic [ChW-1:0]    chan_q, chan_d;

  assign lo_done    = in_lo && (timer_q == TimerW'(RdLow - 1));
  assign hi_done    = in_hi && (timer_q == TimerW'(RdHigh - 1));
  assign first_chan = (chan_q == '0);
  assign last_chan  = (chan_q == ChW'(Channels - 1));

  always_comb begin
    timer_d = timer_q + 1'b1;
    chan_d  = chan_q;
    if (!(in_lo || in_hi)) begin
      // Outside the read phase everything rewinds for the next frame.
      timer_d = '0;
      chan_d  = '0;
    end else if (lo_done) begin
      timer_d = '0;
    end else if (hi_done) begin
      timer_d = '0;
      chan_d  = last_chan ? '0 : chan_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      chan_q  <= '0;
    end else begin
      timer_q <= timer_d;
      chan_q  <= chan_d;
    end
  end

endmodule

// File: rtl/ad_sample_capture.sv
// ADC front-end controller: resets the converter, paces conversions, reads every channel per
// frame, checks FIRSTDATA alignment and forwards words to the acquisition FIFO.
module ad_sample_capture
  import ad_sample_capture_pkg::*;
#(
  parameter int unsigned Dw         = DefaultDw,
  parameter int unsigned Channels   = 8,
  parameter int unsigned SampleDiv  = 1000,
  parameter int unsigned ResetCyc   = 10,
  parameter int unsigned ConvstCyc  = 4,
  parameter int unsigned BusySettle = 4,
  parameter int unsigned BusyTmo    = 500,
  parameter int unsigned RdLow      = 2,
  parameter int unsigned RdHigh     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  ad_sample_capture_if.master adc,
  output logic                data_flag,
  output logic [Dw-1:0]       fifo_data,
  output logic                fifo_wrreq,
  input  logic                fifo_full,
  output logic [OvfW-1:0]     overflow_cnt,
  output logic                sync_err,
  output logic                tick_overrun,
  output logic                busy_tmo
);

  localparam int unsigned TickW = $clog2(SampleDiv);

  state_e            state_q, state_d;
  logic [TimerW-1:0] cnt_q, cnt_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic              tick_pending_q, tick_pending_d;
  logic              busy_s1_q, busy_s2_q;
  logic [Dw-1:0]     fifo_data_q;
  logic              data_flag_q;
  logic [OvfW-1:0]   overflow_q;
  logic              sync_err_q, tick_overrun_q, busy_tmo_q;

  logic in_lo, in_hi, lo_done, hi_done, first_chan, last_chan;
  logic leave_tick, capture, set_sync, set_tmo, set_overrun, tick_run, tick_wrap;

  assign in_lo = (state_q == StRdLo);
  assign in_hi = (state_q == StRdHi);

  ad_sample_capture_rd_seq #(
    .Channels(Channels),
    .RdLow   (RdLow),
    .RdHigh  (RdHigh)
  ) u_rd_seq (
    .clk       (clk),
    .reset     (reset),
    .in_lo     (in_lo),
    .in_hi     (in_hi),
    .lo_done   (lo_done),
    .hi_done   (hi_done),
    .first_chan(first_chan),
    .last_chan (last_chan)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    leave_tick = 1'b0;
    capture    = 1'b0;
    set_sync   = 1'b0;
    set_tmo    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) state_d = StAdRst;
      end
      StAdRst: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TimerW'(ResetCyc - 1)) begin
          state_d = StWaitTick;
          cnt_d   = '0;
        end
      end
      StWaitTick: begin
        cnt_d = '0;
        // A stop request is honoured only between frames.
        if (!start) begin
          state_d = StIdle;
        end else if (tick_pending_q) begin
          state_d    = StConvst;
          leave_tick = 1'b1;
        end
      end
      StConvst: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TimerW'(ConvstCyc - 1)) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TimerW'(BusySettle - 1)) begin
          state_d = StWaitBusy;
          cnt_d   = '0;
        end
      end
      StWaitBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (!busy_s2_q) begin
          state_d = StRdLo;
          cnt_d   = '0;
        end else if (cnt_q == TimerW'(BusyTmo - 1)) begin
          state_d = StWaitTick;
          set_tmo = 1'b1;
          cnt_d   = '0;
        end
      end
      StRdLo: begin
        if (lo_done) begin
          if (adc.first_data != first_chan) begin
            set_sync = 1'b1;
            state_d  = StWaitTick;
          end else begin
            capture = 1'b1;
            state_d = StRdHi;
          end
        end
      end
      StRdHi: begin
        if (hi_done) state_d = last_chan ? StWaitTick : StRdLo;
      end
      default: state_d = StIdle;
    endcase
  end

  // Conversion pacing runs independently of the frame sequence once the ADC is out of reset.
  always_comb begin
    tick_run       = (state_q != StIdle) && (state_q != StAdRst);
    tick_wrap      = tick_run && (tick_cnt_q == TickW'(SampleDiv - 1));
    tick_cnt_d     = (!tick_run || tick_wrap) ? '0 : tick_cnt_q + 1'b1;
    tick_pending_d = tick_run && ((tick_pending_q && !leave_tick) || tick_wrap);
    set_overrun    = tick_wrap && tick_pending_q && !leave_tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      tick_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      busy_s1_q      <= 1'b0;
      busy_s2_q      <= 1'b0;
      fifo_data_q    <= '0;
      data_flag_q    <= 1'b0;
      overflow_q     <= '0;
      sync_err_q     <= 1'b0;
      tick_overrun_q <= 1'b0;
      busy_tmo_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      tick_pending_q <= tick_pending_d;
      busy_s1_q      <= adc.ad_busy;
      busy_s2_q      <= busy_s1_q;
      data_flag_q    <= capture;
      if (capture) fifo_data_q <= adc.ad_data;
      if (data_flag_q && fifo_full) overflow_q <= sat_inc(overflow_q);
      if (set_sync) sync_err_q <= 1'b1;
      if (set_tmo) busy_tmo_q <= 1'b1;
      if (set_overrun) tick_overrun_q <= 1'b1;
    end
  end

  assign adc.ad_reset    = (state_q == StAdRst);
  assign adc.ad_convst_n = (state_q != StConvst);
  assign adc.ad_cs_n     = !(in_lo || in_hi);
  assign adc.ad_rd_n     = !in_lo;

  assign data_flag    = data_flag_q;
  assign fifo_data    = fifo_data_q;
  assign fifo_wrreq   = data_flag_q && !fifo_full;
  assign overflow_cnt = overflow_q;
  assign sync_err     = sync_err_q;
  assign tick_overrun = tick_overrun_q;
  assign busy_tmo     = busy_tmo_q;

endmodule

// File: tb/tb_ad_sample_capture.sv
// Randomised frame-level bench: an ADC model plays per-frame plans, a reference model queues the
// words each plan should produce, and a monitor checks every captured word against that queue.
module tb_ad_sample_capture;

  localparam int Dw        = 16;
  localparam int Ch        = 8;
  localparam int SampleDiv = 200;
  localparam int ResetCyc  = 10;
  localparam int ConvstCyc = 4;
  localparam int RdLow     = 2;
  localparam int NP        = 12;
  localparam int Stuck     = 1000000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          fifo_full = 1'b0;
  logic          data_flag, fifo_wrreq, sync_err, tick_overrun, busy_tmo;
  logic [Dw-1:0] fifo_data;
  logic [15:0]   overflow_cnt;

  ad_sample_capture_if #(.Dw(Dw)) adc ();

  ad_sample_capture #(
    .Dw       (Dw),
    .Channels (Ch),
    .SampleDiv(SampleDiv)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .adc         (adc),
    .data_flag   (data_flag),
    .fifo_data   (fifo_data),
    .fifo_wrreq  (fifo_wrreq),
    .fifo_full   (fifo_full),
    .overflow_cnt(overflow_cnt),
    .sync_err    (sync_err),
    .tick_overrun(tick_overrun),
    .busy_tmo    (busy_tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [Dw-1:0] data;
    logic          wr;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            failures = 0;
  int            p_busy[NP];
  logic [Dw-1:0] p_data[NP][Ch];
  logic          p_fd[NP][Ch];
  logic          p_full[NP][Ch];
  int            exp_ovf = 0;
  logic          exp_sync = 1'b0, exp_tmo = 1'b0, exp_overrun = 1'b0;
  int            exp_reads = 0;
  int            reads_cur = 0;
  int            frames = 0;
  int            cur_f = 0;
  int            busy_left = 0;
  int            rst_pulses = 0;
  logic          meas_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ad_reset"}, 32'(adc.ad_reset), 0);
    check({tag, "_convst_n"}, 32'(adc.ad_convst_n), 1);
    check({tag, "_cs_n"}, 32'(adc.ad_cs_n), 1);
    check({tag, "_rd_n"}, 32'(adc.ad_rd_n), 1);
    check({tag, "_data_flag"}, 32'(data_flag), 0);
    check({tag, "_fifo_wrreq"}, 32'(fifo_wrreq), 0);
    check({tag, "_fifo_data"}, 32'(fifo_data), 0);
    check({tag, "_overflow_cnt"}, 32'(overflow_cnt), 0);
    check({tag, "_sync_err"}, 32'(sync_err), 0);
    check({tag, "_busy_tmo"}, 32'(busy_tmo), 0);
    check({tag, "_tick_overrun"}, 32'(tick_overrun), 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_overflow_cnt"}, 32'(overflow_cnt), 32'(exp_ovf));
    check({tag, "_sync_err"}, 32'(sync_err), 32'(exp_sync));
    check({tag, "_busy_tmo"}, 32'(busy_tmo), 32'(exp_tmo));
    check({tag, "_tick_overrun"}, 32'(tick_overrun), 32'(exp_overrun));
  endtask

  // Called on every conversion start: audit the previous frame, then predict this one.
  task automatic frame_start();
    int f;
    if (frames > 0) check("reads_per_frame", 32'(reads_cur), 32'(exp_reads));
    check_status("frame_status");
    f = (frames < NP) ? frames : 0;
    reads_cur    = 0;
    adc.ad_busy  = 1'b1;
    busy_left    = p_busy[f];
    if (p_busy[f] >= Stuck) begin
      exp_reads   = 0;
      exp_tmo     = 1'b1;
      exp_overrun = 1'b1;
    end else begin
      exp_reads = Ch;
      for (int c = 0; c < Ch; c++) begin
        if (p_fd[f][c] != (c == 0)) begin
          exp_sync  = 1'b1;
          exp_reads = c + 1;
          break;
        end
        sb_q.push_back('{data: p_data[f][c], wr: !p_full[f][c]});
        if (p_full[f][c] && exp_ovf < 65535) exp_ovf++;
      end
    end
    cur_f = f;
    frames++;
  endtask

  // Behavioural ADC: busy after CONVST, one word per RD falling edge while CS is low.
  initial begin : adc_model
    logic prev_cv, prev_rd;
    int   idx;
    prev_cv = 1'b1;
    prev_rd = 1'b1;
    idx     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev_cv     = 1'b1;
        prev_rd     = 1'b1;
        idx         = 0;
        busy_left   = 0;
        adc.ad_busy = 1'b0;
        continue;
      end
      if (prev_cv && !adc.ad_convst_n) begin
        frame_start();
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) adc.ad_busy = 1'b0;
      end
      if (adc.ad_cs_n) begin
        idx = 0;
      end else if (prev_rd && !adc.ad_rd_n) begin
        if (idx < Ch) begin
          adc.ad_data    = p_data[cur_f][idx];
          adc.first_data = p_fd[cur_f][idx];
          fifo_full      = p_full[cur_f][idx];
        end
        idx++;
        reads_cur++;
      end
      prev_cv = adc.ad_convst_n;
      prev_rd = adc.ad_rd_n;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) continue;
      if (fifo_wrreq) check("wrreq_has_flag", 32'(data_flag), 1);
      if (data_flag) begin
        check("word_expected", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("fifo_wrreq", 32'(fifo_wrreq), 32'(e.wr));
          if (e.wr) check("fifo_data", 32'(fifo_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : widths
    int rst_run, cv_run, rd_run;
    rst_run = 0;
    cv_run  = 0;
    rd_run  = 0;
    forever begin
      @(negedge clk);
      if (!reset || !meas_en) begin
        rst_run = 0;
        cv_run  = 0;
        rd_run  = 0;
        continue;
      end
      if (adc.ad_reset) rst_run++;
      else if (rst_run > 0) begin
        check("ad_reset_width", 32'(rst_run), ResetCyc);
        rst_pulses++;
        rst_run = 0;
      end
      if (!adc.ad_convst_n) cv_run++;
      else if (cv_run > 0) begin
        check("convst_width", 32'(cv_run), ConvstCyc);
        cv_run = 0;
      end
      if (!adc.ad_rd_n) rd_run++;
      else if (rd_run > 0) begin
        check("rd_low_width", 32'(rd_run), RdLow);
        rd_run = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not terminate");
  end

  initial begin : main
    bit got;
    for (int f = 0; f < NP; f++) begin
      p_busy[f] = $urandom_range(10, 60);
      for (int c = 0; c < Ch; c++) begin
        p_data[f][c] = 16'($urandom);
        p_fd[f][c]   = (c == 0);
        p_full[f][c] = ($urandom_range(0, 3) == 0);
      end
      if (f >= 5 && $urandom_range(0, 3) == 0) p_fd[f][$urandom_range(1, Ch - 1)] = 1'b1;
    end
    for (int c = 0; c < Ch; c++) begin
      p_data[0][c] = 16'(c);
      p_full[0][c] = 1'b0;
      p_full[1][c] = (c >= 3 && c <= 5);
      p_full[2][c] = 1'b0;
    end
    p_busy[0] = 20;
    p_busy[1] = 20;
    p_busy[2] = 20;
    p_fd[2][0] = 1'b0;
    p_busy[4] = Stuck;

    adc.ad_data    = '0;
    adc.ad_busy    = 1'b0;
    adc.first_data = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;

    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (frames >= NP) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("frames_started", 32'(frames), NP);

    start = 1'b0;
    repeat (600) @(negedge clk);
    check("no_convst_after_stop", 32'(frames), NP);
    check("reads_last_frame", 32'(reads_cur), 32'(exp_reads));
    check_status("final");
    check("final_tick_overrun_set", 32'(tick_overrun), 1);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    check("idle_cs_n", 32'(adc.ad_cs_n), 1);
    check("idle_convst_n", 32'(adc.ad_convst_n), 1);
    check("adc_reset_pulses", 32'(rst_pulses), 1);

    start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!adc.ad_rd_n) begin
        got = 1'b1;
        break;
      end
    end
    check("restart_reaches_read", 32'(got), 1);
    check("adc_reset_pulses_restart", 32'(rst_pulses), 2);
    meas_en = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    sb_q.delete();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
